// File: rtl/parity_frame_rx.sv
// Bit-serial frame receiver: start bit, DATA_BITS data bits LSB-first, one
// parity bit, one stop bit. Accumulates XOR parity as bits arrive and emits
// the parallel word with one-cycle valid / parity-error / framing-error pulses.
module parity_frame_rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned ODD_PARITY = 0
) (
    input  logic                 Clk,
    input  logic                 Resetn,
    input  logic                 Din,
    input  logic                 Din_valid,
    output logic [DATA_BITS-1:0] Dout,
    output logic                 Dout_valid,
    output logic                 Par_err,
    output logic                 Frame_err,
    output logic                 Busy
);

    localparam int unsigned CntW = $clog2(DATA_BITS);
    localparam logic [CntW-1:0] CntMax = CntW'(DATA_BITS - 1);
    localparam logic OddBit = (ODD_PARITY != 0);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  acc_q, acc_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  perr_q, perr_d;
    logic [DATA_BITS-1:0]  dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  frame_err_q, frame_err_d;

    // Next-state: every transition is gated by the bit strobe; idle cycles hold state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        par_err_d    = 1'b0;
        frame_err_d  = 1'b0;

        if (Din_valid) begin
            unique case (state_q)
                StIdle: begin
                    // A high bit is line idle; only a low bit starts a frame.
                    if (!Din) begin
                        state_d = StData;
                        cnt_d   = '0;
                        acc_d   = 1'b0;
                    end
                end
                StData: begin
                    shift_d[cnt_q] = Din;
                    acc_d          = acc_q ^ Din;
                    if (cnt_q == CntMax) begin
                        state_d = StParity;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StParity: begin
                    perr_d  = acc_q ^ Din ^ OddBit;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (Din) begin
                        // Word is delivered even on a parity error; Par_err flags it.
                        dout_d       = shift_q;
                        dout_valid_d = 1'b1;
                        par_err_d    = perr_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            acc_q        <= 1'b0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            par_err_q    <= par_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Outputs: registered pulses and word; Busy decoded straight from state.
    always_comb begin
        Dout       = dout_q;
        Dout_valid = dout_valid_q;
        Par_err    = par_err_q;
        Frame_err  = frame_err_q;
        Busy       = (state_q != StIdle);
    end

endmodule
